// File: rtl/port_alloc_sched_pkg.sv
// Shared constants and helpers for the oldest-first output-port scheduler.
package port_alloc_sched_pkg;

    localparam int unsigned NUM_PORT_DEF = 5;
    localparam int unsigned LOCAL_PORT   = 4;
    localparam int unsigned AGE_W_DEF    = 8;
    localparam int unsigned CNT_W_DEF    = 16;

    // Ports a flit may be deflected to: every port except local eject (5'b01111 for 5 ports).
    function automatic logic [31:0] defl_mask(input int unsigned n);
        logic [31:0] m;
        m = '0;
        for (int unsigned k = 0; k < 32; k++) begin
            if (k < n && k != LOCAL_PORT) begin
                m[k] = 1'b1;
            end
        end
        return m;
    endfunction

endpackage

// File: rtl/port_alloc_step.sv
// Single-flit allocation step: productive port if free, else deflect, else fail.
module port_alloc_step
    import port_alloc_sched_pkg::*;
#(
    parameter int unsigned NUM_PORT = NUM_PORT_DEF
) (
    input  logic                valid,
    input  logic [NUM_PORT-1:0] req,
    input  logic [NUM_PORT-1:0] remaining,
    output logic [NUM_PORT-1:0] grant,
    output logic                deflect,
    output logic                fail,
    output logic [NUM_PORT-1:0] remaining_next
);

    localparam logic [31:0]         DEFL_FULL = defl_mask(NUM_PORT);
    localparam logic [NUM_PORT-1:0] DEFL      = DEFL_FULL[NUM_PORT-1:0];

    // One-hot of the highest set bit; shared by productive and deflection paths.
    function automatic logic [NUM_PORT-1:0] hsb(input logic [NUM_PORT-1:0] v);
        logic [NUM_PORT-1:0] r;
        r = '0;
        for (int k = 0; k < NUM_PORT; k++) begin
            if (v[k]) begin
                r    = '0;
                r[k] = 1'b1;
            end
        end
        return r;
    endfunction

    logic [NUM_PORT-1:0] prod;
    logic [NUM_PORT-1:0] defl;

    // Pick a port for this flit and remove it from the pool.
    always_comb begin
        prod    = req & remaining;
        defl    = remaining & DEFL;
        grant   = '0;
        deflect = 1'b0;
        fail    = 1'b0;
        if (valid) begin
            if (|prod) begin
                grant = hsb(prod);
            end else if (|defl) begin
                grant   = hsb(defl);
                deflect = 1'b1;
            end else begin
                fail = 1'b1;
            end
        end
        remaining_next = remaining & ~grant;
    end

endmodule

// File: rtl/port_alloc_sched.sv
// Two-stage oldest-first output-port scheduler: register inputs, rank by age,
// allocate in rank order through a chain of single-flit steps, register grants.
module port_alloc_sched
    import port_alloc_sched_pkg::*;
#(
    parameter int unsigned NUM_PORT = NUM_PORT_DEF,
    parameter int unsigned AGE_W    = AGE_W_DEF,
    parameter int unsigned CNT_W    = CNT_W_DEF
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic [NUM_PORT-1:0]          in_valid,
    input  logic [NUM_PORT*NUM_PORT-1:0] in_req,
    input  logic [NUM_PORT*AGE_W-1:0]    in_age,
    input  logic [NUM_PORT-1:0]          in_avail,
    output logic [NUM_PORT-1:0]          out_valid,
    output logic [NUM_PORT*NUM_PORT-1:0] out_alloc,
    output logic [NUM_PORT-1:0]          out_deflect,
    output logic [NUM_PORT-1:0]          out_fail,
    output logic [CNT_W-1:0]             deflect_cnt
);

    localparam int unsigned RANK_W = (NUM_PORT > 1) ? $clog2(NUM_PORT) : 1;
    localparam int unsigned POP_W  = $clog2(NUM_PORT + 1);
    localparam int unsigned SUM_W  = CNT_W + POP_W;

    // Stage 1 registers
    logic [NUM_PORT-1:0]          s1_valid_q;
    logic [NUM_PORT*NUM_PORT-1:0] s1_req_q;
    logic [NUM_PORT*AGE_W-1:0]    s1_age_q;
    logic [NUM_PORT-1:0]          s1_avail_q;
    logic [NUM_PORT*NUM_PORT-1:0] req_masked;

    // Stage 2 registers
    logic [NUM_PORT-1:0]          s2_valid_q;
    logic [NUM_PORT*NUM_PORT-1:0] s2_alloc_q;
    logic [NUM_PORT-1:0]          s2_deflect_q;
    logic [NUM_PORT-1:0]          s2_fail_q;
    logic [CNT_W-1:0]             cnt_q;
    logic [CNT_W-1:0]             cnt_d;

    // Ranking and rank-ordered slots
    logic [RANK_W-1:0]   rank       [NUM_PORT];
    logic [NUM_PORT-1:0] sel        [NUM_PORT];
    logic [NUM_PORT-1:0] slot_req   [NUM_PORT];
    logic [NUM_PORT-1:0] slot_valid;
    logic [NUM_PORT-1:0] slot_grant [NUM_PORT];
    logic [NUM_PORT-1:0] slot_defl;
    logic [NUM_PORT-1:0] slot_fail;
    logic [NUM_PORT-1:0] rem        [NUM_PORT+1];

    // Per-input results mapped back from slots
    logic [NUM_PORT*NUM_PORT-1:0] alloc_d;
    logic [NUM_PORT-1:0]          deflect_d;
    logic [NUM_PORT-1:0]          fail_d;

    // Invalid inputs must not carry request bits into stage 1.
    always_comb begin
        req_masked = '0;
        for (int i = 0; i < NUM_PORT; i++) begin
            req_masked[i*NUM_PORT +: NUM_PORT] =
                in_req[i*NUM_PORT +: NUM_PORT] & {NUM_PORT{in_valid[i]}};
        end
    end

    // Stage 1 input register.
    always_ff @(posedge clk) begin
        if (reset) begin
            s1_valid_q <= '0;
            s1_req_q   <= '0;
            s1_age_q   <= '0;
            s1_avail_q <= '0;
        end else begin
            s1_valid_q <= in_valid;
            s1_req_q   <= req_masked;
            s1_age_q   <= in_age;
            s1_avail_q <= in_avail;
        end
    end

    // Rank = number of valid inputs that are older, or equally old with lower index.
    always_comb begin
        for (int i = 0; i < NUM_PORT; i++) begin
            rank[i] = '0;
            for (int j = 0; j < NUM_PORT; j++) begin
                if (j != i && s1_valid_q[j]) begin
                    if ((s1_age_q[j*AGE_W +: AGE_W] > s1_age_q[i*AGE_W +: AGE_W]) ||
                        ((s1_age_q[j*AGE_W +: AGE_W] == s1_age_q[i*AGE_W +: AGE_W]) &&
                         (j < i))) begin
                        rank[i] = rank[i] + 1'b1;
                    end
                end
            end
        end
    end

    // Gather each rank slot's flit; valid inputs hold distinct ranks so sel is one-hot.
    always_comb begin
        for (int r = 0; r < NUM_PORT; r++) begin
            sel[r]        = '0;
            slot_req[r]   = '0;
            for (int i = 0; i < NUM_PORT; i++) begin
                sel[r][i] = s1_valid_q[i] && (rank[i] == RANK_W'(r));
                if (sel[r][i]) begin
                    slot_req[r] = slot_req[r] | s1_req_q[i*NUM_PORT +: NUM_PORT];
                end
            end
            slot_valid[r] = |sel[r];
        end
    end

    assign rem[0] = s1_avail_q;

    for (genvar r = 0; r < NUM_PORT; r++) begin : g_chain
        port_alloc_step #(
            .NUM_PORT(NUM_PORT)
        ) u_step (
            .valid          (slot_valid[r]),
            .req            (slot_req[r]),
            .remaining      (rem[r]),
            .grant          (slot_grant[r]),
            .deflect        (slot_defl[r]),
            .fail           (slot_fail[r]),
            .remaining_next (rem[r+1])
        );
    end

    // Route slot results back to the input that occupied each slot.
    always_comb begin
        alloc_d   = '0;
        deflect_d = '0;
        fail_d    = '0;
        for (int i = 0; i < NUM_PORT; i++) begin
            for (int r = 0; r < NUM_PORT; r++) begin
                if (sel[r][i]) begin
                    alloc_d[i*NUM_PORT +: NUM_PORT] = slot_grant[r];
                    deflect_d[i] = slot_defl[r];
                    fail_d[i]    = slot_fail[r];
                end
            end
        end
    end

    // Saturating add of this cycle's deflections.
    always_comb begin
        logic [POP_W-1:0] pop;
        logic [SUM_W-1:0] sum;
        pop = '0;
        for (int i = 0; i < NUM_PORT; i++) begin
            pop = pop + POP_W'(deflect_d[i]);
        end
        sum = SUM_W'(cnt_q) + SUM_W'(pop);
        if (|sum[SUM_W-1:CNT_W]) begin
            cnt_d = '1;
        end else begin
            cnt_d = sum[CNT_W-1:0];
        end
    end

    // Stage 2 output register and deflection counter.
    always_ff @(posedge clk) begin
        if (reset) begin
            s2_valid_q   <= '0;
            s2_alloc_q   <= '0;
            s2_deflect_q <= '0;
            s2_fail_q    <= '0;
            cnt_q        <= '0;
        end else begin
            s2_valid_q   <= s1_valid_q;
            s2_alloc_q   <= alloc_d;
            s2_deflect_q <= deflect_d;
            s2_fail_q    <= fail_d;
            cnt_q        <= cnt_d;
        end
    end

    assign out_valid   = s2_valid_q;
    assign out_alloc   = s2_alloc_q;
    assign out_deflect = s2_deflect_q;
    assign out_fail    = s2_fail_q;
    assign deflect_cnt = cnt_q;

endmodule

// File: tb/tb_port_alloc_sched.sv
// Directed-vector bench for port_alloc_sched with hand-computed expectations.
module tb_port_alloc_sched;

    logic        clk;
    logic        reset;
    logic [4:0]  in_valid;
    logic [24:0] in_req;
    logic [39:0] in_age;
    logic [4:0]  in_avail;
    logic [4:0]  out_valid;
    logic [24:0] out_alloc;
    logic [4:0]  out_deflect;
    logic [4:0]  out_fail;
    logic [15:0] deflect_cnt;

    // Second instance with a narrow counter for saturation
    logic [4:0]  sat_valid;
    logic [24:0] sat_req;
    logic [39:0] sat_age;
    logic [4:0]  sat_avail;
    logic [4:0]  sat_out_valid;
    logic [24:0] sat_out_alloc;
    logic [4:0]  sat_out_deflect;
    logic [4:0]  sat_out_fail;
    logic [3:0]  sat_cnt;

    int total = 0;
    int bad   = 0;
    int exp_cnt;

    port_alloc_sched dut (
        .clk         (clk),
        .reset       (reset),
        .in_valid    (in_valid),
        .in_req      (in_req),
        .in_age      (in_age),
        .in_avail    (in_avail),
        .out_valid   (out_valid),
        .out_alloc   (out_alloc),
        .out_deflect (out_deflect),
        .out_fail    (out_fail),
        .deflect_cnt (deflect_cnt)
    );

    port_alloc_sched #(
        .CNT_W(4)
    ) dut_sat (
        .clk         (clk),
        .reset       (reset),
        .in_valid    (sat_valid),
        .in_req      (sat_req),
        .in_age      (sat_age),
        .in_avail    (sat_avail),
        .out_valid   (sat_out_valid),
        .out_alloc   (sat_out_alloc),
        .out_deflect (sat_out_deflect),
        .out_fail    (sat_out_fail),
        .deflect_cnt (sat_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic expect_out(input string tag, input logic [4:0] v, input logic [24:0] a,
                              input logic [4:0] d, input logic [4:0] f, input int c);
        check({tag, "_valid"},   64'(out_valid),   64'(v));
        check({tag, "_alloc"},   64'(out_alloc),   64'(a));
        check({tag, "_deflect"}, 64'(out_deflect), 64'(d));
        check({tag, "_fail"},    64'(out_fail),    64'(f));
        check({tag, "_cnt"},     64'(deflect_cnt), 64'(c));
    endtask

    task automatic drive(input logic [4:0] v, input logic [24:0] r, input logic [39:0] a,
                         input logic [4:0] av);
        in_valid = v;
        in_req   = r;
        in_age   = a;
        in_avail = av;
    endtask

    task automatic idle();
        drive(5'b0, 25'b0, 40'b0, 5'b0);
    endtask

    // Apply one set, wait the two-edge latency, leave the bench 1 time unit past the edge.
    task automatic run_one(input logic [4:0] v, input logic [24:0] r, input logic [39:0] a,
                           input logic [4:0] av);
        drive(v, r, a, av);
        @(posedge clk);
        #1 idle();
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset     = 1'b1;
        idle();
        sat_valid = '0;
        sat_req   = '0;
        sat_age   = '0;
        sat_avail = '0;
        repeat (2) @(posedge clk);
        #1;
        expect_out("reset", 5'b0, 25'b0, 5'b0, 5'b0, 0);
        reset = 1'b0;
        exp_cnt = 0;

        // Single flit
        run_one(5'b00001, {5'b0, 5'b0, 5'b0, 5'b0, 5'b00100}, 40'b0, 5'b11111);
        expect_out("single", 5'b00001, 25'h0000004, 5'b0, 5'b0, exp_cnt);

        // Conflict on port 1: older input 1 wins, input 0 deflects to port 3
        run_one(5'b00011, {5'b0, 5'b0, 5'b0, 5'b00010, 5'b00010},
                {8'd0, 8'd0, 8'd0, 8'd9, 8'd3}, 5'b11111);
        exp_cnt = 1;
        expect_out("conflict", 5'b00011, 25'h0000048, 5'b00001, 5'b0, exp_cnt);

        // Eject blocked: local request deflects to port 3
        run_one(5'b00100, {5'b0, 5'b0, 5'b10000, 5'b0, 5'b0}, 40'b0, 5'b01111);
        exp_cnt = 2;
        expect_out("eject_blk", 5'b00100, 25'h0002000, 5'b00100, 5'b0, exp_cnt);

        // Exhaustion with equal ages: index order; input 1 deflects, 2..4 fail
        run_one(5'b11111, {5'b00001, 5'b00001, 5'b00001, 5'b00001, 5'b00001},
                {8'd7, 8'd7, 8'd7, 8'd7, 8'd7}, 5'b00011);
        exp_cnt = 3;
        expect_out("exhaust", 5'b11111, 25'h0000041, 5'b00010, 5'b11100, exp_cnt);

        // Mixed ages: input 3 oldest, then input 0 beats input 1 on index tie
        run_one(5'b01011, {5'b0, 5'b00001, 5'b0, 5'b00001, 5'b00011},
                {8'd0, 8'd7, 8'd0, 8'd5, 8'd5}, 5'b11111);
        exp_cnt = 4;
        expect_out("rank", 5'b01011, 25'h0008102, 5'b00010, 5'b0, exp_cnt);

        // Only local port free with a non-local request
        run_one(5'b00001, {5'b0, 5'b0, 5'b0, 5'b0, 5'b00001}, 40'b0, 5'b10000);
        expect_out("local_only", 5'b00001, 25'h0, 5'b0, 5'b00001, exp_cnt);

        // No ports available at all
        run_one(5'b10010, {5'b00010, 5'b0, 5'b0, 5'b00100, 5'b0}, 40'b0, 5'b00000);
        expect_out("avail0", 5'b10010, 25'h0, 5'b0, 5'b10010, exp_cnt);

        // All inputs invalid, stray request bits ignored
        run_one(5'b00000, {5'b11111, 5'b11111, 5'b11111, 5'b11111, 5'b11111},
                40'hffff_ffff_ff, 5'b11111);
        expect_out("none", 5'b0, 25'h0, 5'b0, 5'b0, exp_cnt);

        // Empty request mask is a pure deflection request
        run_one(5'b10000, 25'b0, 40'b0, 5'b11111);
        exp_cnt = 5;
        expect_out("req0", 5'b10000, 25'h0800000, 5'b10000, 5'b0, exp_cnt);

        // Back-to-back sets emerge in order, one per cycle
        drive(5'b00001, {5'b0, 5'b0, 5'b0, 5'b0, 5'b00001}, 40'b0, 5'b11111);
        @(posedge clk);
        #1 drive(5'b00010, {5'b0, 5'b0, 5'b0, 5'b00010, 5'b0}, {8'd0, 8'd0, 8'd0, 8'd2, 8'd0},
                 5'b11111);
        @(posedge clk);
        #1 drive(5'b01100, {5'b0, 5'b00100, 5'b00100, 5'b0, 5'b0},
                 {8'd0, 8'd1, 8'd1, 8'd0, 8'd0}, 5'b11111);
        expect_out("pipe_a", 5'b00001, 25'h0000001, 5'b0, 5'b0, exp_cnt);
        @(posedge clk);
        #1 idle();
        expect_out("pipe_b", 5'b00010, 25'h0000040, 5'b0, 5'b0, exp_cnt);
        @(posedge clk);
        #1;
        exp_cnt = 6;
        expect_out("pipe_c", 5'b01100, 25'h0041000, 5'b01000, 5'b0, exp_cnt);

        // Reset in the cycle after the second set flushes both stages
        drive(5'b00001, {5'b0, 5'b0, 5'b0, 5'b0, 5'b00001}, 40'b0, 5'b11111);
        @(posedge clk);
        #1 drive(5'b00010, {5'b0, 5'b0, 5'b0, 5'b00010, 5'b0}, 40'b0, 5'b11111);
        @(posedge clk);
        #1 drive(5'b01100, {5'b0, 5'b00100, 5'b00100, 5'b0, 5'b0}, 40'b0, 5'b11111);
        reset = 1'b1;
        expect_out("rst_a", 5'b00001, 25'h0000001, 5'b0, 5'b0, exp_cnt);
        @(posedge clk);
        #1 reset = 1'b0;
        idle();
        exp_cnt = 0;
        expect_out("rst_flush0", 5'b0, 25'h0, 5'b0, 5'b0, exp_cnt);
        @(posedge clk);
        #1 expect_out("rst_flush1", 5'b0, 25'h0, 5'b0, 5'b0, exp_cnt);
        @(posedge clk);
        #1 expect_out("rst_flush2", 5'b0, 25'h0, 5'b0, 5'b0, exp_cnt);

        // Saturation: 3 deflections per cycle into a 4-bit counter
        check("sat_start", 64'(sat_cnt), 64'd0);
        sat_valid = 5'b01111;
        sat_req   = {5'b0, 5'b10000, 5'b10000, 5'b10000, 5'b10000};
        sat_avail = 5'b11111;
        for (int m = 1; m <= 7; m++) begin
            @(posedge clk);
            #1;
            if (m >= 2) begin
                check($sformatf("sat_cnt_%0d", m), 64'(sat_cnt),
                      64'((3 * (m - 1) > 15) ? 15 : 3 * (m - 1)));
            end
        end
        check("sat_defl", 64'(sat_out_deflect), 64'(5'b01110));
        sat_valid = '0;
        repeat (3) @(posedge clk);
        #1 check("sat_hold", 64'(sat_cnt), 64'd15);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
